// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver:
// glyph codes, display mode encoding and the glyph-to-segment decoder.
package seg_pkg;

  localparam logic [4:0] GLYPH_DASH  = 5'h1C;
  localparam logic [4:0] GLYPH_EQ    = 5'h1D;
  localparam logic [4:0] GLYPH_BLANK = 5'h1F;
  localparam logic [7:0] SEG_OFF     = 8'hFF;

  typedef enum logic {
    MODE_HEX  = 1'b0,
    MODE_TEXT = 1'b1
  } disp_mode_e;

  // Returns {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph2seg(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'h00: seg = 7'h40;  // 0
      5'h01: seg = 7'h79;  // 1
      5'h02: seg = 7'h24;  // 2
      5'h03: seg = 7'h30;  // 3
      5'h04: seg = 7'h19;  // 4
      5'h05: seg = 7'h12;  // 5
      5'h06: seg = 7'h02;  // 6
      5'h07: seg = 7'h78;  // 7
      5'h08: seg = 7'h00;  // 8
      5'h09: seg = 7'h10;  // 9
      5'h0A: seg = 7'h08;  // A
      5'h0B: seg = 7'h03;  // b
      5'h0C: seg = 7'h46;  // C
      5'h0D: seg = 7'h21;  // d
      5'h0E: seg = 7'h06;  // E
      5'h0F: seg = 7'h0E;  // F
      5'h10: seg = 7'h42;  // G
      5'h11: seg = 7'h0B;  // h
      5'h12: seg = 7'h09;  // H
      5'h13: seg = 7'h47;  // L
      5'h14: seg = 7'h2B;  // n
      5'h15: seg = 7'h23;  // o
      5'h16: seg = 7'h0C;  // P
      5'h17: seg = 7'h18;  // q
      5'h18: seg = 7'h2F;  // r
      5'h19: seg = 7'h07;  // t
      5'h1A: seg = 7'h41;  // U
      5'h1B: seg = 7'h11;  // y
      5'h1C: seg = 7'h3F;  // -
      5'h1D: seg = 7'h37;  // =
      5'h1E: seg = 7'h12;  // S
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: prescaler producing one tick per digit slot, the current
// digit index, and a frame_end strobe on the tick that leaves the last digit.
module seg_scan_timer #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      o_tick,
  output logic [$clog2(DIGITS)-1:0] o_idx,
  output logic                      o_frame_end
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_tick;
  logic          w_last;

  assign w_tick      = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_last      = (r_idx == IW'(DIGITS - 1));
  assign o_tick      = w_tick;
  assign o_idx       = r_idx;
  assign o_frame_end = w_tick && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit 7-segment driver: staged/shadowed display data swapped
// at frame boundaries, leading-zero blanking, blink, and a blank cycle per switch.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 2**24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  lzb,
  input  logic [4*DIGITS-1:0]   disp_num,
  input  logic [5*DIGITS-1:0]   text_code,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            SEGMENT,
  output logic [DIGITS-1:0]     AN
);

  localparam int IW = $clog2(DIGITS);
  localparam int BW = $clog2(BLINK_DIV);

  logic          w_tick;
  logic          w_frame_end;
  logic [IW-1:0] w_idx;

  seg_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_tick      (w_tick),
    .o_idx       (w_idx),
    .o_frame_end (w_frame_end)
  );

  logic [4*DIGITS-1:0] r_stg_num,  r_shd_num;
  logic [5*DIGITS-1:0] r_stg_txt,  r_shd_txt;
  logic [DIGITS-1:0]   r_stg_dp,   r_shd_dp;
  logic [DIGITS-1:0]   r_stg_blk,  r_shd_blk;
  disp_mode_e          r_stg_mode, r_shd_mode;
  logic                r_stg_lzb,  r_shd_lzb;
  logic                r_pending;

  // Shadow takes the pre-edge stage, so a load coinciding with frame_end
  // stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_num  <= '0;
      r_stg_txt  <= '0;
      r_stg_dp   <= '0;
      r_stg_blk  <= '0;
      r_stg_mode <= MODE_HEX;
      r_stg_lzb  <= 1'b0;
      r_shd_num  <= '0;
      r_shd_txt  <= '0;
      r_shd_dp   <= '0;
      r_shd_blk  <= '0;
      r_shd_mode <= MODE_HEX;
      r_shd_lzb  <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (load) begin
        r_stg_num  <= disp_num;
        r_stg_txt  <= text_code;
        r_stg_dp   <= dp_in;
        r_stg_blk  <= blink_mask;
        r_stg_mode <= disp_mode_e'(mode);
        r_stg_lzb  <= lzb;
      end
      if (w_frame_end && r_pending) begin
        r_shd_num  <= r_stg_num;
        r_shd_txt  <= r_stg_txt;
        r_shd_dp   <= r_stg_dp;
        r_shd_blk  <= r_stg_blk;
        r_shd_mode <= r_stg_mode;
        r_shd_lzb  <= r_stg_lzb;
      end
      if (load) begin
        r_pending <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
    end
  end

  logic [BW-1:0] r_bcnt;
  logic          r_bphase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
      r_bcnt   <= '0;
      r_bphase <= ~r_bphase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // w_lz[i]: digit i and every digit above it hold zero.
  logic [DIGITS-1:0] w_lz;
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_shd_num[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 1; i--) begin
      w_lz[i] = w_lz[i+1] && (r_shd_num[4*i +: 4] == 4'd0);
    end
  end

  logic [3:0] w_nib;
  logic [4:0] w_code;
  logic       w_dp;
  logic       w_blink_off;
  logic [7:0] w_pattern;

  always_comb begin
    w_nib       = r_shd_num[4*w_idx +: 4];
    w_dp        = r_shd_dp[w_idx];
    w_blink_off = r_bphase && r_shd_blk[w_idx];
    if (r_shd_mode == MODE_TEXT) begin
      w_code = r_shd_txt[5*w_idx +: 5];
    end else if (r_shd_lzb && w_lz[w_idx]) begin
      w_code = GLYPH_BLANK;
    end else begin
      w_code = {1'b0, w_nib};
    end
    w_pattern = w_blink_off ? SEG_OFF : {~w_dp, glyph2seg(w_code)};
  end

  // Nothing is lit until the first tick; the tick cycle itself is the dead time.
  logic r_started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      AN        <= '1;
      SEGMENT   <= SEG_OFF;
    end else begin
      r_started <= r_started | w_tick;
      if (w_tick || !r_started) begin
        AN      <= '1;
        SEGMENT <= SEG_OFF;
      end else begin
        AN      <= ~({{(DIGITS-1){1'b0}}, 1'b1} << w_idx);
        SEGMENT <= w_pattern;
      end
    end
  end

endmodule
